// File: rtl/btn_pkg.sv
// Shared button indices, fixed N > W > S > E issue priority and the priority picker
// used by nwse_button_pulser.
package btn_pkg;

  localparam int unsigned BTN_N = 3;
  localparam int unsigned BTN_W = 2;
  localparam int unsigned BTN_S = 1;
  localparam int unsigned BTN_E = 0;

  // Highest priority first.
  localparam int unsigned BTN_PRIO [4] = '{BTN_N, BTN_W, BTN_S, BTN_E};

  // Returns the highest-priority set bit of v as a one-hot vector, or zero.
  function automatic logic [3:0] prio_pick(input logic [3:0] v);
    logic [3:0] r;
    r = '0;
    // Walk lowest to highest so the highest-priority hit is written last.
    for (int i = 3; i >= 0; i--) begin
      if (v[BTN_PRIO[i]]) begin
        r = '0;
        r[BTN_PRIO[i]] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-bit 2-FF synchroniser plus debounce counter; held flips after DEBOUNCE_CYCLES
// consecutive disagreeing cycles, and rise strobes on the cycle whose edge sets held to 1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic held,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip = (sync_2 != held) && (cnt == CNT_LAST);
  // Combinational so the press can be queued on the same edge held rises.
  assign rise = flip && sync_2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the reset here is synchronous, checked inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      held   <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (sync_2 == held) begin
        cnt <= '0;
      end else if (flip) begin
        held <= sync_2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nwse_button_pulser.sv
// Debounces N/W/S/E buttons and issues one-hot single-cycle nwse pulses, one per press,
// serialised N > W > S > E. Define BTN_EXCLUSIVE_EN to drop chords and overlapping presses.
module nwse_button_pulser
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] nwse,
  output logic [3:0] held
);

  logic [3:0] rise;
  logic [3:0] pending;
  logic [3:0] issue;
  logic [3:0] set_mask;

  for (genvar g = 0; g < 4; g++) begin : g_deb
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[g]),
      .held (held[g]),
      .rise (rise[g])
    );
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    issue    = prio_pick(pending);
    set_mask = rise;
`ifdef BTN_EXCLUSIVE_EN
    // Accept a press only when it is the sole rise and nothing else is already held.
    if (!($onehot(rise) && (held == 4'b0000))) set_mask = 4'b0000;
`endif
  end

  // Issue reads the pre-edge pending, so a set and a clear on one edge both land.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      nwse    <= '0;
    end else begin
      nwse    <= issue;
      pending <= (pending & ~issue) | set_mask;
    end
  end

endmodule

// File: tb/tb_nwse_button_pulser.sv
// Directed testbench for nwse_button_pulser with DEBOUNCE_CYCLES = 8. Edge 0 is the
// first rising edge that samples the new btn_raw value (with rst low).
module tb_nwse_button_pulser;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] nwse;
  logic [3:0] held;

  int vectors     = 0;
  int miscompares = 0;

  nwse_button_pulser #(.DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .nwse    (nwse),
    .held    (held)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle away from it before sampling or driving.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input int e, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s edge=%0d got=%h expected=%h", name, e, got, exp);
    end
  endtask

  // Release every button and verify held drops after edge 9 with no pulse.
  task automatic release_all(input string name, input logic [3:0] was_held);
    btn_raw = 4'h0;
    for (int e = 0; e < 14; e++) begin
      tick();
      cmp({name, "_rel_held"}, e, held, (e >= D + 1) ? 4'h0 : was_held);
      cmp({name, "_rel_nwse"}, e, nwse, 4'h0);
    end
  endtask

  // A single clean press: held rises after edge 9, one pulse after edge 10.
  task automatic single_press(input string name, input logic [3:0] b, input int cycles);
    btn_raw = b;
    for (int e = 0; e < cycles; e++) begin
      tick();
      cmp({name, "_held"}, e, held, (e >= D + 1) ? b : 4'h0);
      cmp({name, "_nwse"}, e, nwse, (e == D + 2) ? b : 4'h0);
    end
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    btn_raw = 4'h0;
    for (int e = 0; e < 3; e++) begin
      tick();
      cmp("reset_nwse", e, nwse, 4'h0);
      cmp("reset_held", e, held, 4'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_press;
    single_press("clean_s", 4'h2, 20);
    release_all("clean_s", 4'h2);
  endtask

  task automatic test_bounce;
    // 3-cycle runs never reach D consecutive cycles.
    for (int c = 0; c < 30; c++) begin
      btn_raw = (((c / 3) % 2) == 0) ? 4'h1 : 4'h0;
      tick();
      cmp("bounce_held", c, held, 4'h0);
      cmp("bounce_nwse", c, nwse, 4'h0);
    end
    single_press("bounce_settle", 4'h1, 14);
    release_all("bounce", 4'h1);
  endtask

  task automatic test_chord;
    logic [3:0] exp_n;
    btn_raw = 4'hF;
    for (int e = 0; e < 16; e++) begin
      tick();
`ifdef BTN_EXCLUSIVE_EN
      exp_n = 4'h0;
`else
      case (e)
        D + 2:   exp_n = 4'h8;
        D + 3:   exp_n = 4'h4;
        D + 4:   exp_n = 4'h2;
        D + 5:   exp_n = 4'h1;
        default: exp_n = 4'h0;
      endcase
`endif
      cmp("chord_held", e, held, (e >= D + 1) ? 4'hF : 4'h0);
      cmp("chord_nwse", e, nwse, exp_n);
    end
    release_all("chord", 4'hF);
    single_press("solo_w", 4'h4, 14);
    release_all("solo_w", 4'h4);
  endtask

  task automatic test_reset_mid_pending;
    logic [3:0] exp_n;
    btn_raw = 4'h9;
    for (int e = 0; e <= D + 1; e++) begin
      tick();
      cmp("rstmid_pre_held", e, held, (e >= D + 1) ? 4'h9 : 4'h0);
      cmp("rstmid_pre_nwse", e, nwse, 4'h0);
    end
    rst = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      cmp("rstmid_in_held", e, held, 4'h0);
      cmp("rstmid_in_nwse", e, nwse, 4'h0);
    end
    rst = 1'b0;
    for (int e = 0; e < 14; e++) begin
      tick();
`ifdef BTN_EXCLUSIVE_EN
      exp_n = 4'h0;
`else
      exp_n = (e == D + 2) ? 4'h8 : (e == D + 3) ? 4'h1 : 4'h0;
`endif
      cmp("rstmid_post_held", e, held, (e >= D + 1) ? 4'h9 : 4'h0);
      cmp("rstmid_post_nwse", e, nwse, exp_n);
    end
    release_all("rstmid", 4'h9);
  endtask

  task automatic test_long_hold;
    single_press("long_w", 4'h4, 100);
    release_all("long_w", 4'h4);
  endtask

  initial begin
    rst     = 1'b1;
    btn_raw = 4'h0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_chord();
    test_reset_mid_pending();
    test_long_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nwse_button_pulser.md
# nwse_button_pulser

Converts the four raw, asynchronous, bouncing push-buttons (N, W, S, E) into the debounced, one-hot, single-cycle `nwse` command pulses consumed by the digital-lock state machine. It sits between the board pins and the lock FSM. Each physical press yields exactly one one-cycle pulse. Presses that qualify on the same cycle are serialised so that `nwse` is never multi-hot.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive cycles a synchronised input must differ from its debounced level before the level flips. Must be ≥ 4.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn_raw`  in  4  raw buttons, asynchronous. Bit 3 = N, bit 2 = W, bit 1 = S, bit 0 = E.
- `nwse`  out  4  registered command pulse, same bit mapping. One-hot or zero, high for exactly one cycle per press.
- `held`  out  4  debounced button levels, registered.

## Operation
- Per bit: 2-FF synchroniser, then a debounce counter `cnt` of width $clog2(DEBOUNCE_CYCLES).
  - While sync ≠ `held`, `cnt` increments.
  - While sync = `held`, `cnt` clears to 0. Any bounce restarts qualification.
  - When sync ≠ `held` and `cnt == DEBOUNCE_CYCLES-1`: `held` takes the sync value and `cnt` clears.
  - `cnt` never wraps.
- Press detect: on the edge where a `held` bit goes 0→1, the matching bit of the 4-bit `pending` register is set. Releases (1→0) generate nothing.
- Issue: every cycle, if `pending` ≠ 0, the highest-priority set bit is loaded into `nwse` and cleared from `pending`. Priority order is N > W > S > E. Otherwise `nwse` loads 0.
- Simultaneous set and clear on the same edge: issue uses the old `pending`. Set and clear of different bits both take effect. The same bit cannot be re-set while pending, because a re-press takes ≥ 2·DEBOUNCE_CYCLES cycles. No overflow is possible.
- Reset values: sync flops, `cnt`, `held`, `pending` and `nwse` are all 0.
- Reset mid-operation discards pending presses. A button still physically held after `rst` deasserts is a new press and pulses after the normal latency.

## Timing
- With `btn_raw[i]` rising and stable before edge k:
  - sync stage 2 = 1 after edge k+1.
  - `held[i]` = 1 after edge k+1+D, where D = DEBOUNCE_CYCLES.
  - `nwse[i]` = 1 for the single cycle after edge k+2+D.
- Release follows the same path: `held[i]` = 0 after edge k+1+D. `nwse` is unaffected.
- A glitch lasting fewer than D synchronised cycles produces no change.
- N presses qualifying on the same edge produce N back-to-back single-cycle pulses in priority order. There is no idle cycle between them.

## Configuration
- `BTN_EXCLUSIVE_EN` defined:
  - A 0→1 `held` transition is recorded in `pending` only if no other `held` bit is 1 before the edge and no other bit rises on the same edge.
  - Chords and overlapping presses are silently dropped.
- `BTN_EXCLUSIVE_EN` undefined: every press is recorded and serialised by priority.

## Structure
- Package `btn_pkg` holds:
  - localparams `BTN_N = 3`, `BTN_W = 2`, `BTN_S = 1`, `BTN_E = 0`.
  - the fixed priority order.
  - a function returning the highest-priority one-hot bit of a 4-bit vector.
- Sub-module `btn_debounce` (single bit) contains the synchroniser, counter and `held` register, with parameter DEBOUNCE_CYCLES. It is instantiated 4×. Press detect, `pending` and issue logic live in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 8.

- Clean S press: `btn_raw` = 4'h2 held for 20 cycles → `held` = 4'h2 after edge 9, and exactly one cycle of `nwse` = 4'h2 after edge 10. `nwse` = 0 at all other times.
- Bounce: E toggles 1/0 every 3 cycles for 30 cycles, then stays 1 → no pulse during the bouncing. One `nwse` = 4'h1 pulse 10 cycles after the input settles.
- Chord, macro undefined: `btn_raw` 0→4'hF on one edge → `nwse` = 4'h8, 4'h4, 4'h2, 4'h1 on four consecutive cycles, then 0.
- Chord, `BTN_EXCLUSIVE_EN` defined: the same stimulus → `nwse` stays 0. Then W alone after full release → one 4'h4 pulse.
- Reset mid-pending: N and E rise together, and `rst` is asserted on the edge after `held` = 4'h9. Hold both buttons through reset. → Outputs are 0 during reset; after release, 4'h8 then 4'h1 appear 10 and 11 cycles after `rst` deasserts.
- Long hold and release: W held for 100 cycles then released → exactly one 4'h4 pulse. `held[2]` returns to 0 9 cycles after release, with no further pulse.
